cmd_stream_tx: RTL and testbench

CMD_STREAM_TX -- requirements
Module: cmd_stream_tx

---
 rtl/cmd_stream_tx.sv | 212 +++++++++++++++++++++
 tb/tb_cmd_stream_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_stream_tx.sv
// Serialises one message into a command stream: a 10-byte configuration
// header followed by the message bytes, zero-padded out to whole 64-byte blocks.
module cmd_stream_tx #(
    parameter int BLOCK_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  kk_i,
    input  logic [7:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        src_valid_i,
    input  logic [7:0]  src_data_i,
    output logic        src_ready_o,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int               IDX_W     = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [63:0]      BLOCK_LEN = 64'(BLOCK_BYTES);
    localparam logic [3:0]       CONF_LAST = 4'd9;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_DATA,
        S_PAD,
        S_DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        kk_reg;
    logic [7:0]        nn_reg;
    logic [63:0]       ll_reg;
    logic [63:0]       remaining_reg;
    logic [63:0]       remaining_dec;
    logic [IDX_W-1:0]  idx_reg;
    logic              first_reg;
    logic              last_reg;
    logic [3:0]        conf_cnt_reg;

    logic              valid_reg;
    logic [1:0]        cmd_reg;
    logic [7:0]        data_reg;
    logic              done_reg;
    logic              valid_next;
    logic [1:0]        cmd_next;
    logic [7:0]        data_next;
    logic              done_next;

    logic              xfer;
    logic              blk_emit;
    logic              final_byte;
    logic [1:0]        blk_cmd;
    logic [7:0]        conf_bytes [10];

    // Header layout: kk, nn, then ll little-endian.
    assign conf_bytes[0] = kk_reg;
    assign conf_bytes[1] = nn_reg;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ll_bytes
            assign conf_bytes[gi + 2] = ll_reg[8*gi +: 8];
        end
    endgenerate

    assign src_ready_o   = (state_reg == S_DATA);
    assign busy_o        = (state_reg != S_IDLE);
    assign xfer          = src_valid_i && src_ready_o;
    assign blk_emit      = xfer || (state_reg == S_PAD);
    assign final_byte    = (remaining_reg == 64'd1);
    assign remaining_dec = (state_reg == S_DATA) ? remaining_reg - 64'd1 : remaining_reg;

    assign valid_o = valid_reg;
    assign cmd_o   = cmd_reg;
    assign data_o  = data_reg;
    assign done_o  = done_reg;

    // A single-block message opens with START and continues with LAST.
    always_comb begin
        blk_cmd = CMD_DATA;
        if (first_reg && last_reg) begin
            blk_cmd = (idx_reg == '0) ? CMD_START : CMD_LAST;
        end else if (first_reg) begin
            blk_cmd = CMD_START;
        end else if (last_reg) begin
            blk_cmd = CMD_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start_i) state_next = S_CONF;
            S_CONF: begin
                if (conf_cnt_reg == CONF_LAST) begin
                    state_next = (ll_reg != 64'd0) ? S_DATA : S_PAD;
                end
            end
            S_DATA: begin
                if (xfer && final_byte) begin
                    state_next = (idx_reg == IDX_LAST) ? S_DONE : S_PAD;
                end
            end
            S_PAD:  if (idx_reg == IDX_LAST) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The header byte kk leaves in the accept cycle, so it comes straight from the port.
    always_comb begin
        valid_next = 1'b0;
        cmd_next   = CMD_CONF;
        data_next  = 8'h00;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    valid_next = 1'b1;
                    data_next  = kk_i;
                end
            end
            S_CONF: begin
                valid_next = 1'b1;
                data_next  = conf_bytes[conf_cnt_reg];
            end
            S_DATA: begin
                if (xfer) begin
                    valid_next = 1'b1;
                    cmd_next   = blk_cmd;
                    data_next  = src_data_i;
                end
            end
            S_PAD: begin
                valid_next = 1'b1;
                cmd_next   = blk_cmd;
            end
            S_DONE: done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            cmd_reg       <= CMD_CONF;
            data_reg      <= 8'h00;
            done_reg      <= 1'b0;
            kk_reg        <= 8'h00;
            nn_reg        <= 8'h00;
            ll_reg        <= 64'd0;
            remaining_reg <= 64'd0;
            idx_reg       <= '0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
            conf_cnt_reg  <= 4'd0;
        end else begin
            valid_reg <= valid_next;
            cmd_reg   <= cmd_next;
            data_reg  <= data_next;
            done_reg  <= done_next;

            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        kk_reg        <= kk_i;
                        nn_reg        <= nn_i;
                        ll_reg        <= ll_i;
                        remaining_reg <= ll_i;
                        idx_reg       <= '0;
                        first_reg     <= 1'b1;
                        last_reg      <= (ll_i <= BLOCK_LEN);
                        conf_cnt_reg  <= 4'd1;
                    end
                end
                S_CONF: begin
                    conf_cnt_reg <= (conf_cnt_reg == CONF_LAST) ? 4'd0 : conf_cnt_reg + 4'd1;
                end
                default: ;
            endcase

            // Block flags are re-evaluated when the index wraps into a new block.
            if (blk_emit) begin
                idx_reg       <= idx_reg + IDX_W'(1);
                remaining_reg <= remaining_dec;
                if (idx_reg == IDX_LAST) begin
                    first_reg <= 1'b0;
                    last_reg  <= (remaining_dec <= BLOCK_LEN);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_stream_tx.sv
// Scoreboard bench for cmd_stream_tx: a block-level reference model fills an
// expected-beat queue, a monitor pops and compares every valid output byte.
module tb_cmd_stream_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  kk_i = 8'h00;
    logic [7:0]  nn_i = 8'h00;
    logic [63:0] ll_i = 64'd0;
    logic        src_valid_i = 1'b0;
    logic [7:0]  src_data_i = 8'h00;
    logic        src_ready_o;
    logic        valid_o;
    logic [1:0]  cmd_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    cmd_stream_tx #(.BLOCK_BYTES(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .kk_i        (kk_i),
        .nn_i        (nn_i),
        .ll_i        (ll_i),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .valid_o     (valid_o),
        .cmd_o       (cmd_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] msg_src[$];

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int bytes_seen = 0;
    int low_cnt = 0;
    int src_sent = 0;
    int gap_at = -1;
    int gap_left = 0;
    int rand_pct = 0;
    bit msg_started = 1'b0;
    bit ready_seen = 1'b0;
    bit prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] c, input logic [7:0] d);
        beat_t b;
        b.cmd  = c;
        b.data = d;
        return b;
    endfunction

    // Reference stream: header, then every block position holds a source byte or zero.
    task automatic build_expected(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll);
        int nblk;
        int pos;
        logic [7:0] d;
        logic [1:0] c;
        bit first;
        bit last;
        exp_q.push_back(mk(2'd0, kk));
        exp_q.push_back(mk(2'd0, nn));
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(2'd0, 8'(ll >> (8*i))));
        nblk = (ll == 0) ? 1 : int'((ll + 63) / 64);
        for (int b = 0; b < nblk; b++) begin
            first = (b == 0);
            last  = (b == nblk - 1);
            for (int i = 0; i < 64; i++) begin
                pos = b*64 + i;
                d = (pos < int'(ll)) ? msg_src[pos] : 8'h00;
                if (first && last)  c = (i == 0) ? 2'd1 : 2'd3;
                else if (first)     c = 2'd1;
                else if (last)      c = 2'd3;
                else                c = 2'd2;
                exp_q.push_back(mk(c, d));
            end
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (valid_o) begin
                    msg_started = 1'b1;
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL spurious_valid actual=%0h/%0h required=no byte at %0t",
                                 cmd_o, data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("beat%0d", bytes_seen), {cmd_o, data_o}, {e.cmd, e.data});
                    end
                end else if (msg_started && exp_q.size() > 0) begin
                    low_cnt++;
                end
                if (done_o) begin
                    done_cnt++;
                    chk("done_after_last", prev_valid, 1);
                    chk("done_valid_low", valid_o, 0);
                    chk("done_busy_low", busy_o, 0);
                    msg_started = 1'b0;
                end
                prev_valid = valid_o;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // Source: valid stays high (with junk when nothing is owed) except in stalls.
    initial begin
        bit stall;
        forever begin
            @(negedge clk);
            if (src_ready_o) ready_seen = 1'b1;
            stall = 1'b0;
            if (gap_left > 0 && src_sent == gap_at) begin
                stall = 1'b1;
                gap_left--;
            end else if (rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
                stall = 1'b1;
            end
            src_valid_i = !stall;
            src_data_i  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
            if (src_valid_i && src_ready_o && !reset) begin
                if (src_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL extra_src_xfer actual=accepted required=not ready at %0t", $time);
                end else begin
                    void'(src_q.pop_front());
                    src_sent++;
                end
            end
        end
    end

    task automatic run_msg(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll,
                           input bit abc, input int g_at, input int g_len, input int r_pct,
                           input bit hold_start, input int abort_at);
        int d0;
        int nblk;
        int exp_bytes;
        msg_src.delete();
        for (int i = 0; i < int'(ll); i++) begin
            if (abc) msg_src.push_back((i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'hCC);
            else     msg_src.push_back(8'($urandom));
        end
        exp_q.delete();
        build_expected(kk, nn, ll);
        src_q = msg_src;
        nblk = (ll == 0) ? 1 : int'((ll + 63) / 64);
        exp_bytes = 10 + 64*nblk;
        src_sent = 0;
        gap_at = g_at;
        gap_left = g_len;
        rand_pct = r_pct;
        ready_seen = 1'b0;
        bytes_seen = 0;
        low_cnt = 0;
        msg_started = 1'b0;
        d0 = done_cnt;

        kk_i = kk;
        nn_i = nn;
        ll_i = ll;
        start_i = 1'b1;
        @(negedge clk);
        chk("first_conf", {valid_o, cmd_o, data_o}, {1'b1, 2'd0, kk});
        chk("busy_high", busy_o, 1);
        kk_i = 8'($urandom);
        nn_i = 8'($urandom);
        ll_i = {$urandom, $urandom};
        if (hold_start) repeat (9) @(negedge clk);
        start_i = 1'b0;

        if (abort_at >= 0) begin
            for (int c = 0; c < 2000 && src_sent < abort_at; c++) @(posedge clk);
            chk("abort_reached", src_sent >= abort_at, 1);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_idle", {valid_o, done_o, busy_o, src_ready_o}, 0);
            exp_q.delete();
            src_q.delete();
            msg_started = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            $display("[TB] msg ll=%0d aborted by reset after %0d source bytes", ll, src_sent);
            return;
        end

        for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
        chk("done_seen", done_cnt - d0, 1);
        chk("byte_count", bytes_seen, exp_bytes);
        chk("exp_left", exp_q.size(), 0);
        chk("src_left", src_q.size(), 0);
        if (g_len > 0 && r_pct == 0) chk("valid_gap", low_cnt, g_len);
        if (ll == 0) chk("ready_never", ready_seen, 0);
        $display("[TB] msg kk=%0d nn=%0d ll=%0d bytes=%0d gaps=%0d", kk, nn, ll, bytes_seen, low_cnt);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_cmd", cmd_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", src_ready_o, 0);
        reset = 1'b0;

        run_msg(8'd0, 8'd32, 64'd3, 1'b1, -1, 0, 0, 1'b0, -1);
        run_msg(8'd5, 8'd64, 64'd130, 1'b0, -1, 0, 0, 1'b0, -1);
        run_msg(8'd1, 8'd16, 64'd64, 1'b0, -1, 0, 0, 1'b0, -1);
        run_msg(8'd9, 8'd8, 64'd0, 1'b0, -1, 0, 0, 1'b0, -1);
        run_msg(8'd2, 8'd48, 64'd100, 1'b0, 40, 5, 0, 1'b0, -1);
        run_msg(8'd3, 8'd32, 64'd100, 1'b0, -1, 0, 0, 1'b1, 20);
        run_msg(8'd7, 8'd20, 64'd70, 1'b0, -1, 0, 0, 1'b0, -1);

        for (int n = 0; n < 8; n++) begin
            run_msg(8'($urandom), 8'($urandom), 64'($urandom_range(0, 200)), 1'b0,
                    -1, 0, int'($urandom_range(0, 40)), 1'b0, -1);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
